// File: rtl/mem_resp_fifo_ctl.sv
// Memory request/response FIFO with peek-then-retire reads: the head entry is
// presented on data_out and only removed when the memory engine pulses memfin.
module mem_resp_fifo_ctl #(
    parameter int               DEPTH        = 8,
    parameter int               WIDTH        = 520,
    parameter int               AF_THRESH    = 6,
    parameter int               PRELOAD      = 0,
    parameter logic [WIDTH-1:0] PRELOAD_DATA = {WIDTH{1'b0}}
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     write,
    input  logic                     read,
    input  logic                     memfin,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_valid,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   space,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf_err,
    output logic                     udf_err
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    ZERO_C  = {(AW+1){1'b0}};
    localparam logic [AW:0]    ONE_C   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]    AF_C    = (AW+1)'(AF_THRESH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
        (AF_THRESH < 1) || (AF_THRESH > DEPTH) || (WIDTH < 72)) begin : g_param_err
        $error("mem_resp_fifo_ctl: illegal DEPTH/AF_THRESH/WIDTH parameters");
    end

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] data_out_r;
    logic             data_valid_r;
    logic             ovf_err_r;
    logic             udf_err_r;
    logic [AW:0]      count_s;
    logic             empty_s;
    logic             full_s;

    // Flags are decoded from start-of-cycle pointers; the wrap bit makes full/empty distinct.
    assign count_s = wr_ptr_r - rd_ptr_r;
    assign empty_s = (count_s == ZERO_C);
    assign full_s  = (count_s == DEPTH_C);

    assign data_out    = data_out_r;
    assign data_valid  = data_valid_r;
    assign empty       = empty_s;
    assign full        = full_s;
    assign almost_full = (count_s >= AF_C);
    assign space       = DEPTH_C - count_s;
    assign count       = count_s;
    assign ovf_err     = ovf_err_r;
    assign udf_err     = udf_err_r;

    // Entry storage; only the preload slot is touched by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (PRELOAD != 0) begin
                mem_r[0] <= PRELOAD_DATA;
            end
        end else if (write && !full_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= data_in;
        end
    end

    // Pointer, presentation and sticky error state.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r     <= (PRELOAD != 0) ? ONE_C : ZERO_C;
            rd_ptr_r     <= ZERO_C;
            data_out_r   <= {WIDTH{1'b0}};
            data_valid_r <= 1'b0;
            ovf_err_r    <= 1'b0;
            udf_err_r    <= 1'b0;
        end else begin
            if (write) begin
                if (!full_s) begin
                    wr_ptr_r <= wr_ptr_r + ONE_C;
                end else begin
                    ovf_err_r <= 1'b1;
                end
            end
            if (memfin) begin
                if (data_valid_r) begin
                    rd_ptr_r     <= rd_ptr_r + ONE_C;
                    data_valid_r <= 1'b0;
                    data_out_r   <= {WIDTH{1'b0}};
                end else begin
                    udf_err_r <= 1'b1;
                end
            end
            // Present and retire are exclusive: one needs data_valid low, the other high.
            if (read && !empty_s && !data_valid_r) begin
                data_out_r   <= mem_r[rd_ptr_r[AW-1:0]];
                data_valid_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_resp_fifo_ctl.sv
// Directed bench: one instance without preload (DEPTH 8, AF 6) and one with a
// preloaded entry; every expected value is computed here from the FIFO rules.
module tb_mem_resp_fifo_ctl;

    localparam int          W  = 520;
    localparam logic [W-1:0] PL = {8'h66, 448'h0, 64'heeee_eeee_eeee_ebbb};

    logic clk;
    int   checks;
    int   errors;

    logic [W-1:0] a_data_in, a_data_out;
    logic         a_reset, a_write, a_read, a_memfin;
    logic         a_data_valid, a_empty, a_full, a_almost_full, a_ovf_err, a_udf_err;
    logic [3:0]   a_space, a_count;

    logic [W-1:0] b_data_in, b_data_out;
    logic         b_reset, b_write, b_read, b_memfin;
    logic         b_data_valid, b_empty, b_full, b_almost_full, b_ovf_err, b_udf_err;
    logic [3:0]   b_space, b_count;

    mem_resp_fifo_ctl #(.DEPTH(8), .WIDTH(W), .AF_THRESH(6), .PRELOAD(0)) dut_a (
        .clk(clk), .reset(a_reset), .data_in(a_data_in), .write(a_write),
        .read(a_read), .memfin(a_memfin), .data_out(a_data_out),
        .data_valid(a_data_valid), .empty(a_empty), .full(a_full),
        .almost_full(a_almost_full), .space(a_space), .count(a_count),
        .ovf_err(a_ovf_err), .udf_err(a_udf_err)
    );

    mem_resp_fifo_ctl #(.DEPTH(8), .WIDTH(W), .AF_THRESH(6), .PRELOAD(1),
                        .PRELOAD_DATA(PL)) dut_b (
        .clk(clk), .reset(b_reset), .data_in(b_data_in), .write(b_write),
        .read(b_read), .memfin(b_memfin), .data_out(b_data_out),
        .data_valid(b_data_valid), .empty(b_empty), .full(b_full),
        .almost_full(b_almost_full), .space(b_space), .count(b_count),
        .ovf_err(b_ovf_err), .udf_err(b_udf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input int i);
        logic [63:0] v;
        v = 64'(i);
        return {8'h66, 64'h0123_4578_abcd_efb0 + v, {7{v}}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        a_reset = 1'b1; a_write = 1'b0; a_read = 1'b0; a_memfin = 1'b0; a_data_in = '0;
        b_reset = 1'b1; b_write = 1'b0; b_read = 1'b0; b_memfin = 1'b0; b_data_in = '0;
        step();
        a_reset = 1'b0;
        b_reset = 1'b0;

        // Reset state, no preload
        chk("rst_empty", a_empty, 1);
        chk("rst_full", a_full, 0);
        chk("rst_space", a_space, 8);
        chk("rst_count", a_count, 0);
        chk("rst_dout", a_data_out, 0);
        chk("rst_valid", a_data_valid, 0);
        chk("rst_ovf", a_ovf_err, 0);
        chk("rst_udf", a_udf_err, 0);

        // Fill to full, then one overflowing write
        for (int i = 0; i < 8; i++) begin
            a_write = 1'b1;
            a_data_in = mk(i);
            step();
            chk("fill_count", a_count, i + 1);
            chk("fill_af", a_almost_full, (i + 1) >= 6);
        end
        chk("fill_full", a_full, 1);
        chk("fill_space", a_space, 0);
        chk("fill_ovf_pre", a_ovf_err, 0);
        a_data_in = mk(99);
        step();
        a_write = 1'b0;
        chk("ovf_err", a_ovf_err, 1);
        chk("ovf_count", a_count, 8);

        // Present head, repeated read holds, retire
        a_read = 1'b1;
        step();
        a_read = 1'b0;
        chk("pres_valid", a_data_valid, 1);
        chk("pres_data", a_data_out, mk(0));
        a_read = 1'b1;
        step();
        a_read = 1'b0;
        chk("reread_data", a_data_out, mk(0));
        a_memfin = 1'b1;
        step();
        a_memfin = 1'b0;
        chk("ret_valid", a_data_valid, 0);
        chk("ret_dout", a_data_out, 0);
        chk("ret_count", a_count, 7);
        chk("ret_full", a_full, 0);

        // Drain the rest: entries 1..7 in order, the dropped 9th never appears
        for (int i = 1; i < 8; i++) begin
            a_read = 1'b1;
            step();
            a_read = 1'b0;
            chk("drain_data", a_data_out, mk(i));
            a_memfin = 1'b1;
            step();
            a_memfin = 1'b0;
        end
        chk("drain_count", a_count, 0);
        chk("drain_empty", a_empty, 1);
        a_read = 1'b1;
        step();
        a_read = 1'b0;
        chk("rd_empty_valid", a_data_valid, 0);
        chk("rd_empty_udf", a_udf_err, 0);

        // Write/retire pairs across the pointer wrap
        for (int k = 0; k < 16; k++) begin
            a_write = 1'b1;
            a_data_in = mk(100 + k);
            step();
            a_write = 1'b0;
            chk("wrap_count", a_count, 1);
            a_read = 1'b1;
            step();
            a_read = 1'b0;
            chk("wrap_data", a_data_out, mk(100 + k));
            a_memfin = 1'b1;
            step();
            a_memfin = 1'b0;
        end
        chk("wrap_end_count", a_count, 0);
        chk("wrap_end_empty", a_empty, 1);
        chk("wrap_udf", a_udf_err, 0);
        chk("ovf_sticky", a_ovf_err, 1);

        // memfin with nothing presented
        a_memfin = 1'b1;
        step();
        a_memfin = 1'b0;
        chk("udf_err", a_udf_err, 1);
        chk("udf_count", a_count, 0);

        // Full + write + memfin in one cycle: write dropped, retire happens
        for (int i = 0; i < 8; i++) begin
            a_write = 1'b1;
            a_data_in = mk(200 + i);
            step();
        end
        a_write = 1'b0;
        chk("refill_full", a_full, 1);
        a_read = 1'b1;
        step();
        a_read = 1'b0;
        chk("refill_head", a_data_out, mk(200));
        a_write = 1'b1;
        a_memfin = 1'b1;
        a_data_in = mk(300);
        step();
        a_write = 1'b0;
        a_memfin = 1'b0;
        chk("wfull_fin_count", a_count, 7);
        chk("wfull_fin_ovf", a_ovf_err, 1);
        chk("wfull_fin_full", a_full, 0);

        // Non-full write + retire: count unchanged
        a_read = 1'b1;
        step();
        a_read = 1'b0;
        chk("next_head", a_data_out, mk(201));
        a_write = 1'b1;
        a_memfin = 1'b1;
        a_data_in = mk(301);
        step();
        a_write = 1'b0;
        a_memfin = 1'b0;
        chk("w_fin_count", a_count, 7);

        // read + memfin while presented: retire only
        a_read = 1'b1;
        step();
        chk("rf_head", a_data_out, mk(202));
        a_memfin = 1'b1;
        step();
        a_read = 1'b0;
        a_memfin = 1'b0;
        chk("rf_valid", a_data_valid, 0);
        chk("rf_count", a_count, 6);
        a_read = 1'b1;
        step();
        a_read = 1'b0;
        chk("rf_next", a_data_out, mk(203));

        // Preloaded instance: reset state, mid-stream reset, present preload
        chk("pl_rst_count", b_count, 1);
        chk("pl_rst_empty", b_empty, 0);
        chk("pl_rst_space", b_space, 7);
        for (int i = 0; i < 4; i++) begin
            b_write = 1'b1;
            b_data_in = mk(400 + i);
            step();
        end
        b_write = 1'b0;
        chk("pl_count5", b_count, 5);
        b_read = 1'b1;
        step();
        b_read = 1'b0;
        chk("pl_pres_first", b_data_out, PL);
        b_reset = 1'b1;
        step();
        b_reset = 1'b0;
        chk("pl_mid_count", b_count, 1);
        chk("pl_mid_valid", b_data_valid, 0);
        chk("pl_mid_dout", b_data_out, 0);
        b_read = 1'b1;
        step();
        b_read = 1'b0;
        chk("pl_pres_valid", b_data_valid, 1);
        chk("pl_pres_data", b_data_out, PL);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_resp_fifo_ctl.md
Name: mem_resp_fifo_ctl

Overview:
Parametrised successor of the single-port memory request/response FIFO. It buffers WIDTH-bit memory entries: opcode in [WIDTH-1 -: 8], address in [WIDTH-9 -: 64], payload below. Reads are peek-then-retire: an entry is presented on data_out and is only removed when the memory side signals completion (memfin). The block sits between the EDM PHY request path and the memory engine, and adds exact occupancy, an almost-full threshold, sticky error flags and an optional preloaded entry.

Parameters:
DEPTH, 8, number of entries; power of two, >= 2
WIDTH, 520, entry width in bits; >= 72
AF_THRESH, 6, almost_full asserts when count >= AF_THRESH; range 1..DEPTH
PRELOAD, 0, 1 = entry 0 holds PRELOAD_DATA after reset and count = 1
PRELOAD_DATA, {WIDTH{1'b0}}, preload entry value

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high; clears all state
data_in  in  WIDTH  entry to enqueue
write  in  1  enqueue request, one entry per cycle
read  in  1  request to present the head entry on data_out
memfin  in  1  one-cycle pulse, sampled on clk; retires the presented entry
data_out  out  WIDTH  presented head entry (registered)
data_valid  out  1  data_out holds an unretired head entry
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_full  out  1  count >= AF_THRESH
space  out  $clog2(DEPTH)+1  DEPTH - count
count  out  $clog2(DEPTH)+1  entries stored, including the presented entry
ovf_err  out  1  sticky: write attempted while full
udf_err  out  1  sticky: memfin received while data_valid = 0

Behaviour:
- Storage: DEPTH x WIDTH array. wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits (index plus wrap bit). count = wr_ptr - rd_ptr, modulo 2^(AW+1). Wrap from DEPTH-1 to 0 is natural binary rollover.
- All flags are decoded from the registered pointers and reflect state at the start of the cycle. There is no bypass: conditions below use these start-of-cycle values.
- Reset (reset = 1 at a clk edge): pointers = 0, data_out = 0, data_valid = 0, ovf_err = 0, udf_err = 0.
  - PRELOAD = 0: empty = 1, full = 0, count = 0, space = DEPTH.
  - PRELOAD = 1: mem[0] = PRELOAD_DATA, wr_ptr = 1, empty = 0, count = 1, space = DEPTH-1.
  - Reset mid-operation discards all entries and any outstanding presented entry. Reset has priority over every other input.
- Write: if write && !full, then mem[wr_ptr[AW-1:0]] <= data_in and wr_ptr++. If write && full, the data is dropped, pointers are unchanged, and ovf_err <= 1.
- Present: if read && !empty && !data_valid, then data_out <= mem[rd_ptr] and data_valid <= 1 on the next edge (latency 1). rd_ptr does not move.
  - read while data_valid = 1 is ignored; data_out holds its value.
  - read while empty is ignored and sets no error.
- Retire: if memfin && data_valid, then rd_ptr++, data_valid <= 0, data_out <= 0.
  - memfin && !data_valid: ignored, udf_err <= 1.
  - A retire takes effect one cycle after the pulse; a new read may present the next entry in the following cycle.
- Simultaneous events:
  - write + memfin (valid): both occur; count unchanged.
  - write while full + memfin in the same cycle: write dropped (full sampled at cycle start), ovf_err set, retire occurs.
  - read + memfin with data_valid = 1: retire only; read ignored.
  - write to empty FIFO + read in the same cycle: read ignored; entry enqueued.
- ovf_err and udf_err clear only on reset.
- Elaboration check: $error if DEPTH is not a power of two, AF_THRESH is out of range, or WIDTH < 72.

Test Plan:
- Reset, PRELOAD = 0, DEPTH = 8 -> empty = 1, space = 8, count = 0, data_out = 0, data_valid = 0, errors = 0.
- Write 8 entries (opcode 8'h66, address 64'h0123_4578_abcd_efb0 + i), then a 9th write -> full = 1, almost_full from count 6, space = 0, ovf_err = 1, 9th entry absent.
- read pulse -> data_valid = 1 one cycle later with entry 0; repeated read -> data_out unchanged; memfin -> data_valid = 0, count 8 -> 7, full = 0.
- Drain and refill across the pointer wrap (16 write/retire pairs) -> entries emerge in order; count returns to 0; no errors.
- memfin with data_valid = 0 -> udf_err = 1, count unchanged; write + memfin in the same cycle at count = 8 -> count 7, ovf_err = 1.
- PRELOAD = 1, PRELOAD_DATA opcode 8'h66, low 64 bits 64'heeee_eeee_eeee_ebbb; reset asserted mid-stream at count = 5 -> count = 1, read presents the preload value.
